// File: rtl/action_engine_pkg.sv
// Shared opcodes, sub-action field offsets and container widths for the action engine.
package action_engine_pkg;

    localparam int OP_W     = 4;
    localparam int OP_MSB   = 24;
    localparam int OP_LSB   = 21;
    localparam int SRCA_MSB = 20;
    localparam int SRCA_LSB = 16;
    localparam int SRCB_MSB = 15;
    localparam int SRCB_LSB = 11;
    localparam int IMM_W    = 16;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h3;
    localparam logic [OP_W-1:0] OP_SUBI = 4'h4;
    localparam logic [OP_W-1:0] OP_SET  = 4'h5;
    localparam logic [OP_W-1:0] OP_COPY = 4'h6;
    localparam logic [OP_W-1:0] OP_DROP = 4'hF;

    localparam int CONT_W_6B = 48;
    localparam int CONT_W_4B = 32;
    localparam int CONT_W_2B = 16;

endpackage

// File: rtl/ae_container_alu.sv
// Combinational per-container ALU; arithmetic wraps at DATA_WIDTH, unknown opcodes keep dst.
module ae_container_alu
    import action_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [OP_W-1:0]       op,
    input  logic [DATA_WIDTH-1:0] dst,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [IMM_W-1:0]      imm,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] imm_x;

    // Zero-extends for wide containers, truncates to the low bits for narrow ones.
    assign imm_x = DATA_WIDTH'(imm);

    always_comb begin
        result = dst;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_ADDI: result = a + imm_x;
            OP_SUBI: result = a - imm_x;
            OP_SET:  result = imm_x;
            OP_COPY: result = a;
            default: result = dst;
        endcase
    end

endmodule

// File: rtl/param_action_engine.sv
// Per-container action engine: S1 input register, S2 parallel ALUs, output FIFO with registered head.
// Optional statistics counters are built when ACTION_ENGINE_STATS_EN is defined.
module param_action_engine
    import action_engine_pkg::*;
#(
    parameter int N_6B           = 8,
    parameter int N_4B           = 8,
    parameter int N_2B           = 8,
    parameter int MD_LEN         = 356,
    parameter int ACT_LEN        = 25,
    parameter int DISCARD_BIT    = 128,
    parameter int OUT_FIFO_DEPTH = 4,
    localparam int PHV_LEN  = 48*N_6B + 32*N_4B + 16*N_2B + MD_LEN,
    localparam int ACTV_LEN = (N_6B + N_4B + N_2B + 1) * ACT_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PHV_LEN-1:0]  phv_in,
    input  logic                phv_valid_in,
    input  logic [ACTV_LEN-1:0] action_in,
    input  logic                action_valid_in,
    output logic                ready_out,
    output logic [PHV_LEN-1:0]  phv_out,
    output logic                phv_valid_out,
    input  logic                ready_in,
    output logic                err_out,
    output logic [31:0]         stat_pkt_cnt,
    output logic [31:0]         stat_err_cnt
);

    localparam int O_2B = MD_LEN;
    localparam int O_4B = O_2B + CONT_W_2B*N_2B;
    localparam int O_6B = O_4B + CONT_W_4B*N_4B;
    localparam int AW   = $clog2(OUT_FIFO_DEPTH);
    localparam int CW   = $clog2(OUT_FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_FIFO_DEPTH);

    logic                accept, mismatch, push, pop, load;
    logic                s1_valid;
    logic [PHV_LEN-1:0]  s1_phv;
    logic [ACTV_LEN-1:0] s1_act;
    logic [PHV_LEN-1:0]  s2_phv;
    logic [CW-1:0]       mem_cnt, occ;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [PHV_LEN-1:0]  mem [OUT_FIFO_DEPTH];

    logic [N_6B-1:0][CONT_W_6B-1:0] c6, r6;
    logic [N_4B-1:0][CONT_W_4B-1:0] c4, r4;
    logic [N_2B-1:0][CONT_W_2B-1:0] c2, r2;
    logic [MD_LEN-1:0]              md, md_nxt;
    logic                           unused_md_act;

    // phv_valid_out doubles as the occupancy bit of the registered FIFO head.
    assign occ       = mem_cnt + CW'(phv_valid_out) + CW'(s1_valid);
    assign ready_out = occ < DEPTH_C;
    assign accept    = phv_valid_in & action_valid_in & ready_out;
    assign mismatch  = (phv_valid_in ^ action_valid_in) & ready_out;
    assign push      = s1_valid;
    assign pop       = phv_valid_out & ready_in;
    assign load      = (mem_cnt != '0) & (~phv_valid_out | pop);

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_phv <= phv_in;
            s1_act <= action_in;
        end
    end

    assign c6 = s1_phv[O_6B +: CONT_W_6B*N_6B];
    assign c4 = s1_phv[O_4B +: CONT_W_4B*N_4B];
    assign c2 = s1_phv[O_2B +: CONT_W_2B*N_2B];
    assign md = s1_phv[MD_LEN-1:0];

    for (genvar i = 0; i < N_6B; i++) begin : g_6b
        localparam int AO = ACT_LEN * (1 + N_2B + N_4B + i);
        logic [ACT_LEN-1:0]   act;
        logic [CONT_W_6B-1:0] a, b;
        assign act = s1_act[AO +: ACT_LEN];
        always_comb begin
            a = '0;
            b = '0;
            for (int j = 0; j < N_6B; j++) begin
                if (int'(act[SRCA_MSB:SRCA_LSB]) == j) a = c6[j];
                if (int'(act[SRCB_MSB:SRCB_LSB]) == j) b = c6[j];
            end
        end
        ae_container_alu #(.DATA_WIDTH(CONT_W_6B)) u_alu (
            .op(act[OP_MSB:OP_LSB]), .dst(c6[i]), .a(a), .b(b),
            .imm(act[IMM_W-1:0]), .result(r6[i])
        );
    end

    for (genvar i = 0; i < N_4B; i++) begin : g_4b
        localparam int AO = ACT_LEN * (1 + N_2B + i);
        logic [ACT_LEN-1:0]   act;
        logic [CONT_W_4B-1:0] a, b;
        assign act = s1_act[AO +: ACT_LEN];
        always_comb begin
            a = '0;
            b = '0;
            for (int j = 0; j < N_4B; j++) begin
                if (int'(act[SRCA_MSB:SRCA_LSB]) == j) a = c4[j];
                if (int'(act[SRCB_MSB:SRCB_LSB]) == j) b = c4[j];
            end
        end
        ae_container_alu #(.DATA_WIDTH(CONT_W_4B)) u_alu (
            .op(act[OP_MSB:OP_LSB]), .dst(c4[i]), .a(a), .b(b),
            .imm(act[IMM_W-1:0]), .result(r4[i])
        );
    end

    for (genvar i = 0; i < N_2B; i++) begin : g_2b
        localparam int AO = ACT_LEN * (1 + i);
        logic [ACT_LEN-1:0]   act;
        logic [CONT_W_2B-1:0] a, b;
        assign act = s1_act[AO +: ACT_LEN];
        always_comb begin
            a = '0;
            b = '0;
            for (int j = 0; j < N_2B; j++) begin
                if (int'(act[SRCA_MSB:SRCA_LSB]) == j) a = c2[j];
                if (int'(act[SRCB_MSB:SRCB_LSB]) == j) b = c2[j];
            end
        end
        ae_container_alu #(.DATA_WIDTH(CONT_W_2B)) u_alu (
            .op(act[OP_MSB:OP_LSB]), .dst(c2[i]), .a(a), .b(b),
            .imm(act[IMM_W-1:0]), .result(r2[i])
        );
    end

    // Only the opcode of the metadata sub-action has meaning.
    assign unused_md_act = ^s1_act[OP_LSB-1:0];

    always_comb begin
        md_nxt = md;
        if (s1_act[OP_MSB:OP_LSB] == OP_DROP) md_nxt[DISCARD_BIT] = 1'b1;
    end

    assign s2_phv = {r6, r4, r2, md_nxt};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s2_phv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            err_out       <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            mem_cnt       <= '0;
            phv_out       <= '0;
            phv_valid_out <= 1'b0;
        end else begin
            s1_valid <= accept;
            err_out  <= mismatch;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            mem_cnt <= mem_cnt + CW'(push) - CW'(load);
            if (load) begin
                rd_ptr        <= rd_ptr + 1'b1;
                phv_out       <= mem[rd_ptr];
                phv_valid_out <= 1'b1;
            end else if (pop) begin
                phv_valid_out <= 1'b0;
            end
        end
    end

`ifdef ACTION_ENGINE_STATS_EN
    logic [31:0] pkt_cnt, err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (push && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
            if (mismatch && err_cnt != '1) err_cnt <= err_cnt + 32'd1;
        end
    end

    assign stat_pkt_cnt = pkt_cnt;
    assign stat_err_cnt = err_cnt;
`else
    assign stat_pkt_cnt = '0;
    assign stat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_param_action_engine.sv
// Directed bench for param_action_engine: ALU ops, metadata drop, latency, backpressure, mismatch, reset.
module tb_param_action_engine;

    localparam int N_6B = 8, N_4B = 8, N_2B = 8, MD_LEN = 356, ACT_LEN = 25;
    localparam int DISCARD_BIT = 128, DEPTH = 4;
    localparam int PHV_LEN  = 48*N_6B + 32*N_4B + 16*N_2B + MD_LEN;
    localparam int ACTV_LEN = (N_6B + N_4B + N_2B + 1) * ACT_LEN;
    localparam int O2 = MD_LEN, O4 = O2 + 16*N_2B, O6 = O4 + 32*N_4B;
    localparam int A2 = ACT_LEN, A4 = ACT_LEN*(1+N_2B), A6 = ACT_LEN*(1+N_2B+N_4B);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [PHV_LEN-1:0]  phv_in = '0;
    logic                phv_valid_in = 1'b0;
    logic [ACTV_LEN-1:0] action_in = '0;
    logic                action_valid_in = 1'b0;
    logic                ready_out;
    logic [PHV_LEN-1:0]  phv_out;
    logic                phv_valid_out;
    logic                ready_in = 1'b1;
    logic                err_out;
    logic [31:0]         stat_pkt_cnt, stat_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    param_action_engine #(
        .N_6B(N_6B), .N_4B(N_4B), .N_2B(N_2B), .MD_LEN(MD_LEN), .ACT_LEN(ACT_LEN),
        .DISCARD_BIT(DISCARD_BIT), .OUT_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .phv_in(phv_in), .phv_valid_in(phv_valid_in),
        .action_in(action_in), .action_valid_in(action_valid_in), .ready_out(ready_out),
        .phv_out(phv_out), .phv_valid_out(phv_valid_out), .ready_in(ready_in),
        .err_out(err_out), .stat_pkt_cnt(stat_pkt_cnt), .stat_err_cnt(stat_err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PHV_LEN-1:0] setc(input logic [PHV_LEN-1:0] p, input int cls,
                                                input int i, input logic [47:0] v);
        case (cls)
            2:       p[O2 + 16*i +: 16] = v[15:0];
            4:       p[O4 + 32*i +: 32] = v[31:0];
            default: p[O6 + 48*i +: 48] = v;
        endcase
        return p;
    endfunction

    function automatic logic [63:0] getc(input logic [PHV_LEN-1:0] p, input int cls, input int i);
        case (cls)
            2:       return 64'(p[O2 + 16*i +: 16]);
            4:       return 64'(p[O4 + 32*i +: 32]);
            default: return 64'(p[O6 + 48*i +: 48]);
        endcase
    endfunction

    function automatic logic [ACTV_LEN-1:0] seta(input logic [ACTV_LEN-1:0] a, input int cls,
                                                 input int i, input logic [3:0] op,
                                                 input logic [4:0] sa, input logic [15:0] imm);
        case (cls)
            2:       a[A2 + ACT_LEN*i +: ACT_LEN] = {op, sa, imm};
            4:       a[A4 + ACT_LEN*i +: ACT_LEN] = {op, sa, imm};
            default: a[A6 + ACT_LEN*i +: ACT_LEN] = {op, sa, imm};
        endcase
        return a;
    endfunction

    function automatic logic [PHV_LEN-1:0] mkbase();
        logic [PHV_LEN-1:0] p;
        p = '0;
        p[63:0] = 64'hDEAD_BEEF_0123_4567;
        for (int i = 0; i < 8; i++) begin
            p = setc(p, 2, i, 48'h0200 + 48'(i));
            p = setc(p, 4, i, 48'h0400_0000 + 48'(i));
            p = setc(p, 6, i, 48'h0600_0000_0000 + 48'(i));
        end
        return p;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge with valids low.
    task automatic send(input logic [PHV_LEN-1:0] p, input logic [ACTV_LEN-1:0] a);
        phv_in = p;
        action_in = a;
        phv_valid_in = 1'b1;
        action_valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        phv_valid_in = 1'b0;
        action_valid_in = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [PHV_LEN-1:0] exp, output int waited);
        waited = 0;
        while (!phv_valid_out && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, 64'(phv_valid_out), 64'd1);
        chk({tag, "_eq"}, 64'(phv_out === exp), 64'd1);
    endtask

    task automatic pop_out();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [PHV_LEN-1:0]  b, p, e;
        logic [ACTV_LEN-1:0] a;
        int                  w, k;
        logic                r;

        b = mkbase();
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(phv_valid_out), 64'd0);
        chk("rst_data_zero", 64'(phv_out === '0), 64'd1);
        chk("rst_err", 64'(err_out), 64'd0);
        chk("rst_ready", 64'(ready_out), 64'd1);
        chk("rst_stat_pkt", 64'(stat_pkt_cnt), 64'd0);
        chk("rst_stat_err", 64'(stat_err_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // valid mismatch: phv without action
        phv_in = b;
        phv_valid_in = 1'b1;
        @(negedge clk);
        phv_valid_in = 1'b0;
        chk("mm_err_pulse", 64'(err_out), 64'd1);
        @(negedge clk);
        chk("mm_err_clear", 64'(err_out), 64'd0);
`ifdef ACTION_ENGINE_STATS_EN
        chk("mm_stat_err", 64'(stat_err_cnt), 64'd1);
        chk("mm_stat_pkt", 64'(stat_pkt_cnt), 64'd0);
`else
        chk("mm_stat_err", 64'(stat_err_cnt), 64'd0);
        chk("mm_stat_pkt", 64'(stat_pkt_cnt), 64'd0);
`endif
        repeat (3) @(negedge clk);
        chk("mm_no_out", 64'(phv_valid_out), 64'd0);

        // ADD 4B[2] = 0x10 + 0xFFFFFFFF, with latency check
        p = setc(b, 4, 2, 48'h10);
        p = setc(p, 4, 3, 48'hFFFF_FFFF);
        a = seta('0, 4, 2, 4'd1, 5'd2, 16'h1800);
        e = setc(p, 4, 2, 48'hF);
        send(p, a);
        chk("lat_c1", 64'(phv_valid_out), 64'd0);
        @(negedge clk);
        chk("lat_c2", 64'(phv_valid_out), 64'd0);
        @(negedge clk);
        chk("lat_c3", 64'(phv_valid_out), 64'd1);
        chk("add_4b2", getc(phv_out, 4, 2), 64'h0000_000F);
        wait_out("add", e, w);
        pop_out();

        // SUBI 2B, SET 6B, COPY out-of-range src, metadata drop
        p = setc(b, 2, 0, 48'h3);
        a = seta('0, 2, 0, 4'd4, 5'd0, 16'h0005);
        a = seta(a, 6, 7, 4'd5, 5'd0, 16'hBEEF);
        a = seta(a, 4, 1, 4'd6, 5'd9, 16'h0000);
        a[ACT_LEN-1 -: 4] = 4'hF;
        e = setc(p, 2, 0, 48'hFFFE);
        e = setc(e, 6, 7, 48'hBEEF);
        e = setc(e, 4, 1, 48'h0);
        e[DISCARD_BIT] = 1'b1;
        send(p, a);
        wait_out("mix", e, w);
        chk("subi_2b0", getc(phv_out, 2, 0), 64'hFFFE);
        chk("set_6b7", getc(phv_out, 6, 7), 64'h0000_0000_BEEF);
        chk("copy_oor", getc(phv_out, 4, 1), 64'h0);
        chk("md_drop", 64'(phv_out[DISCARD_BIT]), 64'd1);
        pop_out();

        // SUB, ADDI, COPY, unlisted op, out-of-range src_b, md op 0
        a = seta('0, 4, 0, 4'd2, 5'd5, 16'h3000);
        a = seta(a, 6, 0, 4'd3, 5'd1, 16'hFFFF);
        a = seta(a, 2, 5, 4'd6, 5'd7, 16'h0000);
        a = seta(a, 2, 6, 4'd7, 5'd1, 16'h0000);
        a = seta(a, 6, 3, 4'd2, 5'd3, 16'h0000);
        a = seta(a, 2, 1, 4'd1, 5'd1, 16'h0800);
        a = seta(a, 2, 7, 4'd1, 5'd7, 16'hF800);
        e = setc(b, 4, 0, 48'hFFFF_FFFF);
        e = setc(e, 6, 0, 48'h0600_0001_0000);
        e = setc(e, 2, 5, 48'h0207);
        e = setc(e, 6, 3, 48'h3);
        e = setc(e, 2, 1, 48'h0402);
        send(b, a);
        wait_out("ops", e, w);
        chk("sub_4b0", getc(phv_out, 4, 0), 64'hFFFF_FFFF);
        chk("addi_6b0", getc(phv_out, 6, 0), 64'h0600_0001_0000);
        chk("nop7_2b6", getc(phv_out, 2, 6), 64'h0206);
        chk("srcb_oor", getc(phv_out, 2, 7), 64'h0207);
        chk("md_keep", 64'(phv_out[DISCARD_BIT]), 64'd0);
        pop_out();

        // backpressure: stream 6 PHVs into a stalled output
        ready_in = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            r = ready_out;
            phv_in = setc(b, 4, 0, 48'hA000_0000 + 48'(k));
            action_in = '0;
            phv_valid_in = 1'b1;
            action_valid_in = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (r) k++;
        end
        phv_valid_in = 1'b0;
        action_valid_in = 1'b0;
        chk("stall_accepted", 64'(k), 64'd4);
        chk("stall_ready", 64'(ready_out), 64'd0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_hold_vld", 64'(phv_valid_out), 64'd1);
            chk("stall_hold_dat", getc(phv_out, 4, 0), 64'hA000_0000);
            @(negedge clk);
        end
        ready_in = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_out("drain", setc(b, 4, 0, 48'hA000_0000 + 48'(j)), w);
            chk("drain_b2b", 64'(w), 64'd0);
            pop_out();
        end
        for (int j = 4; j < 6; j++) begin
            chk("rest_ready", 64'(ready_out), 64'd1);
            send(setc(b, 4, 0, 48'hA000_0000 + 48'(j)), '0);
            wait_out("rest", setc(b, 4, 0, 48'hA000_0000 + 48'(j)), w);
            pop_out();
        end

        // reset while PHVs are in flight
        ready_in = 1'b0;
        for (int j = 0; j < 3; j++) send(setc(b, 2, 3, 48'h5500 + 48'(j)), '0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(phv_valid_out), 64'd0);
        chk("mid_rst_data", 64'(phv_out === '0), 64'd1);
        chk("mid_rst_ready", 64'(ready_out), 64'd1);
        rst = 1'b0;
        ready_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_rst_empty", 64'(phv_valid_out), 64'd0);
        send(setc(b, 2, 3, 48'h7777), '0);
        wait_out("post_rst", setc(b, 2, 3, 48'h7777), w);
        pop_out();
        chk("post_rst_drain", 64'(phv_valid_out), 64'd0);
`ifdef ACTION_ENGINE_STATS_EN
        chk("end_stat_pkt", 64'(stat_pkt_cnt), 64'd1);
        chk("end_stat_err", 64'(stat_err_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
